// File: rtl/cache_fill_arbiter.sv
// N-channel cache miss-service controller: arbitrates misses, issues word-by-word block fills and interleaves write-through stores.
// Define FILL_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (lowest channel index wins).
module cache_fill_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_miss,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic                    wr_req,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    output logic                    wr_ack,
    output logic                    wr_stall,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic                    mem_en,
    output logic                    mem_wr,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic                    mem_valid,
    output logic [ADDR_W-1:0]       fill_addr,
    output logic [DATA_W-1:0]       fill_data,
    output logic [N_REQ-1:0]        fill_data_we,
    output logic [N_REQ-1:0]        fill_tag_we
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(WORDS);
    localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(WORDS * 2 - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} stateT;

    stateT              r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [ADDR_W-1:0]  r_base;
    logic [CNT_W-1:0]   r_issueCnt;
    logic [CNT_W-1:0]   r_recvCnt;

    logic               w_anyMiss;
    logic [IDX_W-1:0]   w_winIdx;
    logic [ADDR_W-1:0]  w_winAddr;
    logic               w_store;
    logic               w_fillHit;
    logic               w_lastWord;
    logic [ADDR_W-1:0]  w_issueOff;
    logic [ADDR_W-1:0]  w_recvOff;

`ifdef FILL_ARB_RR_EN
    logic [IDX_W-1:0]   r_rrPtr;
    int                 w_rrIdx;

    // Walk channels from the one after the last grant; the descending loop leaves the nearest requester as winner.
    always_comb begin
        w_winIdx = '0;
        w_rrIdx  = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_rrIdx = (int'(r_rrPtr) + 1 + k) % N_REQ;
            for (int i = 0; i < N_REQ; i++) begin
                if (w_rrIdx == i && req_miss[i]) begin
                    w_winIdx = IDX_W'(i);
                end
            end
        end
    end
`else
    always_comb begin
        w_winIdx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_miss[i]) begin
                w_winIdx = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        w_winAddr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_winIdx == IDX_W'(i)) begin
                w_winAddr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign w_anyMiss  = |req_miss;
    assign w_store    = (r_state == IDLE) && wr_req;
    assign w_fillHit  = (r_state != IDLE) && mem_valid;
    assign w_lastWord = w_fillHit && (r_recvCnt == LAST_CNT);
    assign w_issueOff = ADDR_W'({r_issueCnt, 1'b0});
    assign w_recvOff  = ADDR_W'({r_recvCnt, 1'b0});

    // Stores take precedence in IDLE; a miss is only latched in an IDLE cycle with no store pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_base     <= '0;
            r_issueCnt <= '0;
            r_recvCnt  <= '0;
`ifdef FILL_ARB_RR_EN
            r_rrPtr    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (!wr_req && w_anyMiss) begin
                        r_state    <= FILL;
                        r_grant    <= N_REQ'(1) << w_winIdx;
                        r_base     <= w_winAddr & BLOCK_MASK;
                        r_issueCnt <= '0;
                        r_recvCnt  <= '0;
`ifdef FILL_ARB_RR_EN
                        r_rrPtr    <= w_winIdx;
`endif
                    end
                end
                FILL: begin
                    r_issueCnt <= r_issueCnt + CNT_W'(1);
                    if (r_issueCnt == LAST_CNT) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_lastWord) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
            if (w_fillHit) begin
                r_recvCnt <= r_recvCnt + CNT_W'(1);
            end
        end
    end

    assign busy         = (r_state != IDLE);
    assign grant        = r_grant;
    assign wr_ack       = w_store;
    assign wr_stall     = wr_req && (r_state != IDLE);
    assign mem_en       = w_store || (r_state == FILL);
    assign mem_wr       = w_store;
    assign mem_addr     = w_store ? wr_addr : ((r_state == FILL) ? (r_base + w_issueOff) : '0);
    assign mem_wdata    = w_store ? wr_data : '0;
    assign fill_addr    = w_fillHit ? (r_base + w_recvOff) : '0;
    assign fill_data    = w_fillHit ? mem_rdata : '0;
    assign fill_data_we = w_fillHit ? r_grant : '0;
    assign fill_tag_we  = w_lastWord ? r_grant : '0;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter (N_REQ=2, WORDS=8) with a fixed 4-cycle-latency read memory model.
module tb_cache_fill_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_miss;
   logic [31:0] req_addr;
   logic        wr_req;
   logic [15:0] wr_addr;
   logic [15:0] wr_data;
   logic        wr_ack;
   logic        wr_stall;
   logic [1:0]  grant;
   logic        busy;
   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_valid;
   logic [15:0] fill_addr;
   logic [15:0] fill_data;
   logic [1:0]  fill_data_we;
   logic [1:0]  fill_tag_we;

   int checks = 0;
   int errors = 0;

   logic [3:0]  pipeValid = 4'b0000;
   logic [15:0] pipeAddr0, pipeAddr1, pipeAddr2, pipeAddr3;

   cache_fill_arbiter #(
      .N_REQ(2), .ADDR_W(16), .DATA_W(16), .WORDS(8)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_miss(req_miss), .req_addr(req_addr),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ack(wr_ack), .wr_stall(wr_stall),
      .grant(grant), .busy(busy),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_valid(mem_valid),
      .fill_addr(fill_addr), .fill_data(fill_data),
      .fill_data_we(fill_data_we), .fill_tag_we(fill_tag_we)
   );

   // 10-unit clock period
   always #5 clk = ~clk;

   // Memory model: a read issued in cycle t returns in cycle t+4 with data = address ^ 0xBEEF; never reset
   always @(posedge clk) begin
      pipeValid <= {pipeValid[2:0], mem_en && !mem_wr};
      pipeAddr0 <= mem_addr;
      pipeAddr1 <= pipeAddr0;
      pipeAddr2 <= pipeAddr1;
      pipeAddr3 <= pipeAddr2;
   end

   assign mem_valid = pipeValid[3];
   assign mem_rdata = pipeAddr3 ^ 16'hBEEF;

   // Compare one observed value against its expected value
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drive all request inputs at once
   task automatic applyStimulus(input logic [1:0] miss, input logic [15:0] addr0, input logic [15:0] addr1,
                                input logic wreq, input logic [15:0] waddr, input logic [15:0] wdata);
      req_miss = miss;
      req_addr = {addr1, addr0};
      wr_req   = wreq;
      wr_addr  = waddr;
      wr_data  = wdata;
   endtask

   // Expected outputs in cycle c (1 = first FILL cycle) of a block fill with 4-cycle memory latency
   task automatic checkFillCycle(input int c, input logic [15:0] base, input logic [1:0] g);
      logic [15:0] issueAddr;
      logic [15:0] recvAddr;
      logic        inFlight;
      issueAddr = base + 16'(2 * (c - 1));
      recvAddr  = base + 16'(2 * (c - 5));
      inFlight  = (c >= 5) && (c <= 12);
      checkOutput("busy", 32'(busy), 32'(c <= 12));
      checkOutput("grant", 32'(grant), (c <= 12) ? 32'(g) : 32'h0);
      checkOutput("memEn", 32'(mem_en), 32'(c <= 8));
      checkOutput("memWr", 32'(mem_wr), 32'h0);
      if (c <= 8) checkOutput("memAddr", 32'(mem_addr), 32'(issueAddr));
      checkOutput("fillDataWe", 32'(fill_data_we), inFlight ? 32'(g) : 32'h0);
      checkOutput("fillTagWe", 32'(fill_tag_we), (c == 12) ? 32'(g) : 32'h0);
      if (inFlight) begin
         checkOutput("fillAddr", 32'(fill_addr), 32'(recvAddr));
         checkOutput("fillData", 32'(fill_data), 32'(recvAddr ^ 16'hBEEF));
      end
   endtask

   // Safety net so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Directed sequence: inputs change on the falling edge, outputs are checked 1 unit later
   initial begin
      rst_n = 1'b0;
      applyStimulus(2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      #1;
      checkOutput("rstBusy", 32'(busy), 32'h0);
      checkOutput("rstGrant", 32'(grant), 32'h0);
      checkOutput("rstMemEn", 32'(mem_en), 32'h0);
      checkOutput("rstMemAddr", 32'(mem_addr), 32'h0);
      checkOutput("rstWrAck", 32'(wr_ack), 32'h0);
      checkOutput("rstFillWe", 32'(fill_data_we), 32'h0);

      // Single miss on channel 0; req_miss drops after the grant and the fill still completes
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(2'b01, 16'h1236, 16'h0000, 1'b0, 16'h0000, 16'h0000);
      #1;
      checkOutput("sampleBusy", 32'(busy), 32'h0);
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk);
         if (c == 1) req_miss = 2'b00;
         #1;
         checkFillCycle(c, 16'h1230, 2'b01);
      end

      // Both channels miss: channel 0 first, a store arrives in fill cycle 3 and stalls
      @(negedge clk);
      applyStimulus(2'b11, 16'h2004, 16'h4A1C, 1'b0, 16'h0000, 16'h0000);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) req_miss = 2'b10;
         if (c == 3) begin
            wr_req  = 1'b1;
            wr_addr = 16'h0F00;
            wr_data = 16'h5A5A;
         end
         #1;
         checkFillCycle(c, 16'h2000, 2'b01);
         if (c >= 3) begin
            checkOutput("stallDuringFill", 32'(wr_stall), 32'h1);
            checkOutput("noAckDuringFill", 32'(wr_ack), 32'h0);
         end
      end
      @(negedge clk);
      #1;
      checkOutput("storeAck", 32'(wr_ack), 32'h1);
      checkOutput("storeStall", 32'(wr_stall), 32'h0);
      checkOutput("storeMemEn", 32'(mem_en), 32'h1);
      checkOutput("storeMemWr", 32'(mem_wr), 32'h1);
      checkOutput("storeMemAddr", 32'(mem_addr), 32'h0F00);
      checkOutput("storeMemWdata", 32'(mem_wdata), 32'h5A5A);
      checkOutput("storeBusy", 32'(busy), 32'h0);
      checkOutput("storeGrant", 32'(grant), 32'h0);
      wr_req = 1'b0;
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk);
         if (c == 1) req_miss = 2'b00;
         #1;
         checkFillCycle(c, 16'h4A10, 2'b10);
      end

      // Store and miss together in IDLE: store first, fill afterwards, then reset mid-DRAIN
      @(negedge clk);
      applyStimulus(2'b01, 16'h0800, 16'h4A1C, 1'b1, 16'h0A02, 16'h1234);
      #1;
      checkOutput("comboAck", 32'(wr_ack), 32'h1);
      checkOutput("comboMemWr", 32'(mem_wr), 32'h1);
      checkOutput("comboMemAddr", 32'(mem_addr), 32'h0A02);
      checkOutput("comboMemWdata", 32'(mem_wdata), 32'h1234);
      checkOutput("comboBusy", 32'(busy), 32'h0);
      @(negedge clk);
      wr_req = 1'b0;
      #1;
      checkOutput("comboLatchAck", 32'(wr_ack), 32'h0);
      checkOutput("comboLatchBusy", 32'(busy), 32'h0);
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         if (c == 1) req_miss = 2'b00;
         #1;
         checkFillCycle(c, 16'h0800, 2'b01);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midRstBusy", 32'(busy), 32'h0);
      checkOutput("midRstGrant", 32'(grant), 32'h0);
      checkOutput("midRstMemEn", 32'(mem_en), 32'h0);
      checkOutput("midRstMemAddr", 32'(mem_addr), 32'h0);
      checkOutput("midRstFillDataWe", 32'(fill_data_we), 32'h0);
      checkOutput("midRstFillTagWe", 32'(fill_tag_we), 32'h0);
      checkOutput("midRstFillAddr", 32'(fill_addr), 32'h0);
      for (int c = 11; c <= 13; c++) begin
         @(negedge clk);
         rst_n = 1'b1;
         #1;
         checkOutput("staleFillDataWe", 32'(fill_data_we), 32'h0);
         checkOutput("staleFillTagWe", 32'(fill_tag_we), 32'h0);
         checkOutput("staleBusy", 32'(busy), 32'h0);
      end

      // Top-of-memory block: 0xFFFE maps to base 0xFFF0 and addresses stop at 0xFFFE
      @(negedge clk);
      applyStimulus(2'b01, 16'hFFFE, 16'h0000, 1'b0, 16'h0000, 16'h0000);
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk);
         if (c == 1) req_miss = 2'b00;
         #1;
         checkFillCycle(c, 16'hFFF0, 2'b01);
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
